level_progress_ctrl: RTL

Game-progress initiator that pairs with the level controller. Counts player hits and misses per level, issues a one-cycle `incLevel` request when the level quota is met, and waits for the controller's `newLevel` or `victory` acknowledgement. Also owns the symbol-generation timer, using the controller's `symGenMax` as the tick period. Sits between the symbol-match logic and the level controller.

---
 rtl/level_pkg.sv | 33 +++
 rtl/level_progress_ctrl_if.sv | 37 +++
 rtl/sym_tick_timer.sv | 57 +++++
 rtl/level_progress_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : level_pkg
//  Description : Shared types and constants for the level-progress initiator
//                and its symbol-generation timer.
//  Revision    : 1.0  initial release
// ============================================================================
package level_pkg;

    typedef enum logic [2:0] {
        LP_RUN      = 3'd0,
        LP_REQ      = 3'd1,
        LP_WAIT_ACK = 3'd2,
        LP_DONE     = 3'd3,
        LP_OVER     = 3'd4
    } lp_state_e;

    localparam int LEVEL_W    = 4;
    localparam int SYMGEN_W   = 32;
    localparam int MAX_LEVEL  = 9;
    localparam int HIT_CNT_W  = 4;
    localparam int MISS_CNT_W = 2;

    localparam logic [SYMGEN_W-1:0] SYMGEN_MAX_DEFAULT = 32'd100_000_000;

    // Wrap threshold of the symbol timer. A period of 0 behaves like 1, so
    // the threshold never underflows.
    function automatic logic [SYMGEN_W-1:0] sym_threshold(input logic [SYMGEN_W-1:0] period);
        return (period == '0) ? '0 : period - 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/level_progress_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : level_progress_ctrl_if
//  Description : Bundle between the symbol-match logic / level controller
//                (master side) and level_progress_ctrl (slave side).
//  Revision    : 1.0  initial release
//  Signals     : hit, miss, newLevel, victory, symGenMax  -> into controller
//                incLevel, symTick, hitCount, missCount,
//                gameOver, busy                           <- from controller
// ============================================================================
interface level_progress_ctrl_if;
    import level_pkg::*;

    logic                  hit;
    logic                  miss;
    logic                  newLevel;
    logic                  victory;
    logic [SYMGEN_W-1:0]   symGenMax;

    logic                  incLevel;
    logic                  symTick;
    logic [HIT_CNT_W-1:0]  hitCount;
    logic [MISS_CNT_W-1:0] missCount;
    logic                  gameOver;
    logic                  busy;

    modport master (
        output hit, miss, newLevel, victory, symGenMax,
        input  incLevel, symTick, hitCount, missCount, gameOver, busy
    );

    modport slave (
        input  hit, miss, newLevel, victory, symGenMax,
        output incLevel, symTick, hitCount, missCount, gameOver, busy
    );
endinterface
`default_nettype wire

// File: rtl/sym_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sym_tick_timer
//  Description : Free-running period counter producing a registered one-cycle
//                tick each time the count reaches period-1.
//  Revision    : 1.0  initial release
//  Ports       : Clk100M, Rst_n (async, active low)
//                enable  - advance the counter this cycle
//                clear   - force the counter to 0 (wins over enable)
//                period  - tick period in cycles (0 treated as 1)
//                tick    - registered one-cycle pulse
// ============================================================================
module sym_tick_timer
    import level_pkg::*;
(
    input  logic                Clk100M,
    input  logic                Rst_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [SYMGEN_W-1:0] period,
    output logic                tick
);

    logic [SYMGEN_W-1:0] count_q, count_d;
    logic                tick_q, tick_d;

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            // >= rather than == so a period lowered below the current count
            // ticks straight away instead of running round the full range.
            if (count_q >= sym_threshold(period)) begin
                count_d = '0;
                tick_d  = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/level_progress_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : level_progress_ctrl
//  Description : Counts hits/misses per level, requests the next level with a
//                one-cycle incLevel pulse once the hit quota is met, retries
//                when the controller does not acknowledge, and owns the
//                symbol-generation timer.
//  Revision    : 1.0  initial release
//  Ports       : Clk100M, Rst_n (async, active low)
//                bus (level_progress_ctrl_if.slave): hit, miss, newLevel,
//                victory, symGenMax in; incLevel, symTick, hitCount,
//                missCount, gameOver, busy out (all registered)
//  Macro       : LEVEL_MISS_LIMIT_EN - enables miss counting, OVER, gameOver
// ============================================================================
module level_progress_ctrl
    import level_pkg::*;
#(
    parameter int HITS_PER_LEVEL = 8,
    parameter int MISS_LIMIT     = 3,
    parameter int ACK_TIMEOUT    = 16
) (
    input  logic          Clk100M,
    input  logic          Rst_n,
    level_progress_ctrl_if.slave bus
);

    localparam int                    WAIT_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [HIT_CNT_W-1:0]  HIT_TARGET  = HIT_CNT_W'(HITS_PER_LEVEL);
    localparam logic [WAIT_W-1:0]     WAIT_TARGET = WAIT_W'(ACK_TIMEOUT);

    lp_state_e            state_q, state_d;
    logic [HIT_CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic                 inc_q, inc_d;
    logic                 busy_q, busy_d;
    logic                 timer_en, timer_clr;

`ifdef LEVEL_MISS_LIMIT_EN
    localparam logic [MISS_CNT_W-1:0] MISS_TARGET = MISS_CNT_W'(MISS_LIMIT);
    logic [MISS_CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic                  over_q, over_d;
`endif

    always_comb begin
        state_d   = state_q;
        hit_cnt_d = hit_cnt_q;
        wait_d    = wait_q;
        timer_clr = 1'b0;
`ifdef LEVEL_MISS_LIMIT_EN
        miss_cnt_d = miss_cnt_q;
`endif
        case (state_q)
            LP_RUN: begin
                // newLevel is deliberately not looked at here.
                if (bus.victory) begin
                    state_d = LP_DONE;
                end else if (bus.hit) begin
                    // A hit coinciding with a miss wins; the miss is dropped.
                    hit_cnt_d = hit_cnt_q + 1'b1;
                    if (hit_cnt_d == HIT_TARGET) begin
                        state_d = LP_REQ;
                    end
                end
`ifdef LEVEL_MISS_LIMIT_EN
                else if (bus.miss) begin
                    miss_cnt_d = miss_cnt_q + 1'b1;
                    if (miss_cnt_d == MISS_TARGET) begin
                        state_d = LP_OVER;
                    end
                end
`endif
            end
            LP_REQ: begin
                wait_d  = '0;
                state_d = bus.victory ? LP_DONE : LP_WAIT_ACK;
            end
            LP_WAIT_ACK: begin
                if (bus.victory) begin
                    state_d = LP_DONE;
                end else if (bus.newLevel) begin
                    hit_cnt_d = '0;
`ifdef LEVEL_MISS_LIMIT_EN
                    miss_cnt_d = '0;
`endif
                    timer_clr = 1'b1;
                    state_d   = LP_RUN;
                end else begin
                    wait_d = wait_q + 1'b1;
                    if (wait_d == WAIT_TARGET) begin
                        state_d = LP_REQ;
                    end
                end
            end
            default: begin
                // DONE and OVER hold until reset.
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe.
    always_comb begin
        inc_d  = (state_d == LP_REQ);
        busy_d = (state_d == LP_REQ) || (state_d == LP_WAIT_ACK);
`ifdef LEVEL_MISS_LIMIT_EN
        over_d = (state_d == LP_OVER);
`endif
    end

    // The timer also stops on the cycle that enters a terminal state so no
    // tick leaks out once DONE/OVER is showing.
    assign timer_en = (state_q == LP_RUN) &&
                      (state_d != LP_DONE) && (state_d != LP_OVER);

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= LP_RUN;
            hit_cnt_q <= '0;
            wait_q    <= '0;
            inc_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hit_cnt_q <= hit_cnt_d;
            wait_q    <= wait_d;
            inc_q     <= inc_d;
            busy_q    <= busy_d;
        end
    end

`ifdef LEVEL_MISS_LIMIT_EN
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            miss_cnt_q <= '0;
            over_q     <= 1'b0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            over_q     <= over_d;
        end
    end

    assign bus.missCount = miss_cnt_q;
    assign bus.gameOver  = over_q;
`else
    assign bus.missCount = '0;
    assign bus.gameOver  = 1'b0;
`endif

    sym_tick_timer u_sym_tick_timer (
        .Clk100M (Clk100M),
        .Rst_n   (Rst_n),
        .enable  (timer_en),
        .clear   (timer_clr),
        .period  (bus.symGenMax),
        .tick    (bus.symTick)
    );

    assign bus.incLevel = inc_q;
    assign bus.hitCount = hit_cnt_q;
    assign bus.busy     = busy_q;

endmodule
`default_nettype wire
